// File: rtl/mc_pkg.sv
// Shared helpers for the memory-controller read path.
// Used by mc_read_arbiter_rr and mc_rr_grant.
package mc_pkg;

  localparam int MC_MAX_READ_LATENCY = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [3:0] onehot_to_index(
    input logic [15:0] oh
  );
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/mc_rr_grant.sv
// Eligible-to-grant picker: round-robin under MC_ROUND_ROBIN_EN,
// otherwise fixed priority with the lowest index winning.
module mc_rr_grant #(
  parameter int NUM_PORTS = 2
) (
`ifdef MC_ROUND_ROBIN_EN
  input  logic                 clk,
  input  logic                 rst,
`endif
  input  logic [NUM_PORTS-1:0] eligible,
  output logic [NUM_PORTS-1:0] grant
);
  import mc_pkg::*;

`ifdef MC_ROUND_ROBIN_EN
  localparam int PW = (NUM_PORTS > 1) ?
                      clog2(NUM_PORTS) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;
  logic [3:0]    g_idx;
  logic [4:0]    g_nxt;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it
  // becomes lowest priority next cycle.
  always_comb begin
    ptr_n = ptr;
    g_idx = onehot_to_index(16'(grant));
    g_nxt = {1'b0, g_idx} + 5'd1;
    if (found) begin
      if (int'(g_nxt) >= NUM_PORTS)
        ptr_n = '0;
      else
        ptr_n = PW'(g_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_n;
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && eligible[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mc_read_arbiter_rr.sv
// Multi-port read arbiter onto one pipelined memory read port.
// Define MC_ROUND_ROBIN_EN for round-robin, else fixed priority.
module mc_read_arbiter_rr #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            pValid,
  output logic [NUM_PORTS-1:0]            ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] address_in,
  output logic [NUM_PORTS-1:0]            valid,
  input  logic [NUM_PORTS-1:0]            nReady,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  output logic                            read_enable,
  output logic [ADDR_WIDTH-1:0]           read_address,
  input  logic [DATA_WIDTH-1:0]           data_from_memory,
  output logic                            busy
);
  import mc_pkg::*;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] inflight;
  logic [NUM_PORTS-1:0] valid_q;
  logic [NUM_PORTS-1:0] capture;

  logic [READ_LATENCY-1:0][NUM_PORTS-1:0]  tag_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    data_q;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr_v;

  assign addr_v = address_in;

  // A port may issue only with no read outstanding and a
  // slot that is empty or being drained this cycle.
  assign eligible = pValid & ~inflight &
                    (~valid_q | nReady) &
                    {NUM_PORTS{~rst}};

  mc_rr_grant #(
    .NUM_PORTS (NUM_PORTS)
  ) u_grant (
`ifdef MC_ROUND_ROBIN_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .eligible (eligible),
    .grant    (grant)
  );

  assign capture     = tag_q[READ_LATENCY-1];
  assign ready       = grant;
  assign read_enable = |grant;
  assign valid       = valid_q;
  assign data_out    = data_q;
  assign busy        = (|inflight) | (|valid_q);

  always_comb begin
    read_address = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant[i]) read_address = read_address | addr_v[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= grant;
      for (int k = 1; k < READ_LATENCY; k++)
        tag_q[k] <= tag_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      valid_q  <= '0;
    end else begin
      inflight <= (inflight & ~capture) | grant;
      valid_q  <= capture | (valid_q & ~nReady);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (capture[i]) data_q[i] <= data_from_memory;
    end
  end

endmodule

// File: tb/tb_mc_read_arbiter_rr.sv
// Randomized bench for mc_read_arbiter_rr against a
// transaction-level model of arbitration, memory and slots.
module tb_mc_read_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int L  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      pValid;
  logic [N-1:0]      ready;
  logic [N*AW-1:0]   address_in;
  logic [N-1:0]      valid;
  logic [N-1:0]      nReady;
  logic [N*DW-1:0]   data_out;
  logic              read_enable;
  logic [AW-1:0]     read_address;
  logic [DW-1:0]     data_from_memory;
  logic              busy;

  mc_read_arbiter_rr #(
    .NUM_PORTS    (N),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (L)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pValid           (pValid),
    .ready            (ready),
    .address_in       (address_in),
    .valid            (valid),
    .nReady           (nReady),
    .data_out         (data_out),
    .read_enable      (read_enable),
    .read_address     (read_address),
    .data_from_memory (data_from_memory),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic [AW-1:0] addr;
    int          due;
  } rd_t;

  rd_t           pend[$];
  bit            m_inf[N];
  bit            m_val[N];
  logic [DW-1:0] m_dat[N];
  int            m_ptr;
  int            cyc;

  function automatic logic [DW-1:0] memf(
    input logic [AW-1:0] a
  );
    return {a, ~a} ^ 32'h1357_9bdf;
  endfunction

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < N; i++) begin
      m_inf[i] = 1'b0;
      m_val[i] = 1'b0;
      m_dat[i] = '0;
    end
    m_ptr = 0;
  endtask

  initial begin
    int            g;
    int            cap_port;
    int            start;
    bit            idle;
    bit            any_busy;
    logic [N-1:0]  exp_g;
    logic [AW-1:0] exp_a;
    logic [AW-1:0] g_addr;

    rst = 1'b1;
    pValid = '0;
    nReady = '0;
    address_in = '0;
    data_from_memory = '0;
    cyc = 0;
    model_clear();
    repeat (2) @(negedge clk);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = (c == 0) || (c >= 700 && c < 703);
      if (rst) model_clear();
      idle = (c >= 400 && c < 430);
      for (int i = 0; i < N; i++) begin
        pValid[i] = idle ? 1'b0 :
                    ($urandom_range(0, 99) < 60);
        nReady[i] = ($urandom_range(0, 99) < 70);
        address_in[i*AW +: AW] = AW'($urandom);
      end
      if (c >= 200 && c < 260) nReady[1] = 1'b0;
      if (c >= 900 && c < 960) nReady = '1;

      cap_port = -1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        cap_port = pend[0].port;
        data_from_memory = memf(pend[0].addr);
      end else begin
        data_from_memory = $urandom;
      end

      #1;
      g = -1;
      if (!rst) begin
`ifdef MC_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (start + k) % N;
          if (g < 0 && pValid[idx] && !m_inf[idx] &&
              (!m_val[idx] || nReady[idx]))
            g = idx;
        end
      end

      exp_g = '0;
      exp_a = '0;
      g_addr = '0;
      if (g >= 0) begin
        exp_g[g] = 1'b1;
        g_addr = address_in[g*AW +: AW];
        exp_a = g_addr;
      end
      any_busy = 1'b0;
      for (int i = 0; i < N; i++)
        any_busy |= m_inf[i] | m_val[i];

      check("ready", 64'(ready), 64'(exp_g));
      check("read_enable", 64'(read_enable),
            64'(g >= 0));
      check("read_address", 64'(read_address),
            64'(exp_a));
      check("busy", 64'(busy), 64'(any_busy));
      for (int i = 0; i < N; i++) begin
        check($sformatf("valid[%0d]", i),
              64'(valid[i]), 64'(m_val[i]));
        check($sformatf("data_out[%0d]", i),
              64'(data_out[i*DW +: DW]), 64'(m_dat[i]));
      end

      @(posedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++)
          if (m_val[i] && nReady[i]) m_val[i] = 1'b0;
        if (cap_port >= 0) begin
          m_val[cap_port] = 1'b1;
          m_dat[cap_port] = data_from_memory;
          m_inf[cap_port] = 1'b0;
          void'(pend.pop_front());
        end
        if (g >= 0) begin
          m_inf[g] = 1'b1;
          pend.push_back('{g, g_addr, cyc + L});
          m_ptr = (g + 1) % N;
        end
      end
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
